// File: rtl/bcd_timebase_pkg.sv
// Shared constants and the binary-to-BCD helper for bcd_timebase.
// Optional feature macro: BCD_SATURATE_EN (clamp counts above MAX_COUNT to 9999).
package bcd_timebase_pkg;

    localparam int          SLOW_HALF_DEF = 500000;
    localparam int          DISP_HALF_DEF = 50000;
    localparam logic [15:0] MAX_COUNT     = 16'd9999;
    localparam int          DIGIT_W       = 8;

    // Shift-add-3 conversion. Five BCD digits are needed internally to hold
    // any 16-bit value; only the lower four are returned, which yields the
    // value modulo 10000 for free.
    function automatic logic [15:0] bin2bcd(input logic [15:0] bin);
        logic [19:0] bcd;
        bcd = '0;
        for (int i = 15; i >= 0; i--) begin
            for (int d = 0; d < 5; d++) begin
                if (bcd[d*4 +: 4] >= 4'd5)
                    bcd[d*4 +: 4] = bcd[d*4 +: 4] + 4'd3;
            end
            bcd = {bcd[18:0], bin[i]};
        end
        return bcd[15:0];
    endfunction

endpackage

// File: rtl/bcd_timebase_if.sv
// Data bundle of bcd_timebase: count in, decimal digits and divided clocks out.
interface bcd_timebase_if;
    import bcd_timebase_pkg::*;

    logic [15:0]        count;
    logic [DIGIT_W-1:0] digit0;
    logic [DIGIT_W-1:0] digit1;
    logic [DIGIT_W-1:0] digit2;
    logic [DIGIT_W-1:0] digit3;
    logic               slow_clk;
    logic               slow_tick;
    logic               display_clk;

    modport master (
        output count,
        input  digit0, digit1, digit2, digit3, slow_clk, slow_tick, display_clk
    );

    modport slave (
        input  count,
        output digit0, digit1, digit2, digit3, slow_clk, slow_tick, display_clk
    );
endinterface

// File: rtl/bcd_timebase_clk_divider.sv
// Square-wave divider: counter 0..HALF-1, output toggles when the counter wraps.
// rise pulses for the single cycle in which clk_out goes 0->1.
module clk_divider #(
    parameter int HALF = 1
) (
    input  logic clk,
    input  logic reset_n,
    output logic clk_out,
    output logic rise
);
    localparam int           W    = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [W-1:0] LAST = W'(HALF - 1);

    logic [W-1:0] r_cnt;
    logic         r_clk_out;
    logic         r_rise;

    // Half-period counter; rise is registered alongside the toggle so both
    // change on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_rise    <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt     <= '0;
            r_clk_out <= ~r_clk_out;
            r_rise    <= ~r_clk_out;
        end else begin
            r_cnt     <= r_cnt + W'(1);
            r_rise    <= 1'b0;
        end
    end

    assign clk_out = r_clk_out;
    assign rise    = r_rise;
endmodule

// File: rtl/bcd_timebase.sv
// Registered binary-to-decimal display driver plus two independent timebases.
// Optional feature macro: BCD_SATURATE_EN. When defined, counts above 9999
// display 9999; otherwise the display shows count modulo 10000.
module bcd_timebase
    import bcd_timebase_pkg::*;
#(
    parameter int SLOW_HALF = SLOW_HALF_DEF,
    parameter int DISP_HALF = DISP_HALF_DEF
) (
    input  logic          clk,
    input  logic          reset_n,
    bcd_timebase_if.slave bus
);
    logic [15:0]        w_value;
    logic [15:0]        w_bcd;
    logic [DIGIT_W-1:0] r_digit0;
    logic [DIGIT_W-1:0] r_digit1;
    logic [DIGIT_W-1:0] r_digit2;
    logic [DIGIT_W-1:0] r_digit3;
    logic               w_slow_clk;
    logic               w_slow_tick;
    logic               w_disp_clk;
    logic               w_disp_rise_unused;

    // Select the value to convert (clamped or raw) and convert it.
    always_comb begin
`ifdef BCD_SATURATE_EN
        w_value = (bus.count > MAX_COUNT) ? MAX_COUNT : bus.count;
`else
        w_value = bus.count;
`endif
        w_bcd = bin2bcd(w_value);
    end

    // Single output register stage; upper nibble of each digit stays zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_digit0 <= '0;
            r_digit1 <= '0;
            r_digit2 <= '0;
            r_digit3 <= '0;
        end else begin
            r_digit0 <= {{(DIGIT_W-4){1'b0}}, w_bcd[3:0]};
            r_digit1 <= {{(DIGIT_W-4){1'b0}}, w_bcd[7:4]};
            r_digit2 <= {{(DIGIT_W-4){1'b0}}, w_bcd[11:8]};
            r_digit3 <= {{(DIGIT_W-4){1'b0}}, w_bcd[15:12]};
        end
    end

    clk_divider #(.HALF(SLOW_HALF)) u_slow_div (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_out (w_slow_clk),
        .rise    (w_slow_tick)
    );

    clk_divider #(.HALF(DISP_HALF)) u_disp_div (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_out (w_disp_clk),
        .rise    (w_disp_rise_unused)
    );

    assign bus.digit0      = r_digit0;
    assign bus.digit1      = r_digit1;
    assign bus.digit2      = r_digit2;
    assign bus.digit3      = r_digit3;
    assign bus.slow_clk    = w_slow_clk;
    assign bus.slow_tick   = w_slow_tick;
    assign bus.display_clk = w_disp_clk;
endmodule

// File: tb/tb_bcd_timebase.sv
// Bench for bcd_timebase: scoreboard on the digit path, directed checks on
// the dividers and on asynchronous reset.
module tb_bcd_timebase;

    typedef struct {
        int          cnt;
        logic [31:0] digits;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;
    exp_t sb_q[$];
    logic        last_valid;
    logic [31:0] last_digits;

    bcd_timebase_if bus();

    bcd_timebase #(.SLOW_HALF(5), .DISP_HALF(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_digits(input int v);
        int x;
        int d0, d1, d2, d3;
`ifdef BCD_SATURATE_EN
        x = (v > 9999) ? 9999 : v;
`else
        x = v % 10000;
`endif
        d0 = x % 10;
        d1 = (x / 10) % 10;
        d2 = (x / 100) % 10;
        d3 = x / 1000;
        return {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] dut_digits();
        return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    task automatic apply(input int v);
        exp_t e;
        @(negedge clk);
        bus.count = 16'(v);
        e.cnt = v;
        e.digits = ref_digits(v);
        sb_q.push_back(e);
    endtask

    // Monitor: digits settle one cycle after the stimulus edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check($sformatf("digits(count=%0d)", e.cnt), dut_digits(), e.digits);
            last_valid  = 1'b1;
            last_digits = e.digits;
        end
    end

    // Between edges the digits must hold the last registered value.
    always @(negedge clk) begin
        if (last_valid)
            check("digits_hold", dut_digits(), last_digits);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        last_valid = 1'b0;
        last_digits = '0;
        reset_n = 1'b0;
        bus.count = 16'd7;
        #2;
        check("reset_digits", dut_digits(), 32'h0);
        check("reset_clks", {29'b0, bus.slow_clk, bus.slow_tick, bus.display_clk}, 32'h0);

        // Divider timing from reset release (edge 1 is the first rising edge after release).
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 1; n <= 27; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("slow_clk@%0d", n), {31'b0, bus.slow_clk}, 32'((n / 5) % 2));
            check($sformatf("slow_tick@%0d", n), {31'b0, bus.slow_tick},
                  32'(((n % 5) == 0) && (((n / 5) % 2) == 1)));
            check($sformatf("display_clk@%0d", n), {31'b0, bus.display_clk}, 32'((n / 2) % 2));
        end

        // Mid-period asynchronous reset: slow_clk, display_clk and digits are all high/nonzero here.
        #3;
        reset_n = 1'b0;
        #1;
        check("midreset_digits", dut_digits(), 32'h0);
        check("midreset_clks", {29'b0, bus.slow_clk, bus.slow_tick, bus.display_clk}, 32'h0);
        bus.count = 16'd0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("rel_slow_clk@%0d", n), {31'b0, bus.slow_clk}, 32'(n >= 5));
            check($sformatf("rel_slow_tick@%0d", n), {31'b0, bus.slow_tick}, 32'(n == 5));
            check($sformatf("rel_display_clk@%0d", n), {31'b0, bus.display_clk}, 32'((n / 2) % 2));
        end

        // Directed digit vectors, then an exhaustive sweep changing every cycle.
        apply(0);
        apply(1234);
        apply(9999);
        apply(10);
        apply(12345);
        apply(10000);
        apply(65535);
        apply(5);
        for (int v = 0; v <= 9999; v++)
            apply(v);
        apply(42);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_timebase.md
BCD_TIMEBASE -- requirements
Module: bcd_timebase

Interface
REQ-001 SHALL have parameter SLOW_HALF, default 500000: clk cycles per half-period of slow_clk (100 Hz at 100 MHz).
REQ-002 SHALL have parameter DISP_HALF, default 50000: clk cycles per half-period of display_clk (1 kHz at 100 MHz).
REQ-003 SHALL have port clk  input  1  single system clock; all state is updated on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port count  input  16  binary value to convert, nominal range 0..9999.
REQ-006 SHALL have ports digit0, digit1, digit2, digit3  output  8 each  decimal ones, tens, hundreds and thousands, each 0..9, zero-extended.
REQ-007 SHALL have port slow_clk  output  1  divided square wave that paces the counting logic.
REQ-008 SHALL have port slow_tick  output  1  one-clk pulse coincident with each slow_clk rising transition.
REQ-009 SHALL have port display_clk  output  1  divided square wave that paces the seven-segment multiplexing.

Function
REQ-010 Conversion SHALL be registered: digits reflect the count sampled at the previous clk edge (1-cycle latency), with no other pipeline stages.
REQ-011 For count <= 9999, digits SHALL satisfy 1000*digit3 + 100*digit2 + 10*digit1 + digit0 == count, with each digit in 0..9.
REQ-012 Digit bits [7:4] SHALL always be 0.
REQ-013 For count > 9999, behaviour SHALL follow REQ-021.
REQ-014 Each divider SHALL use a counter 0..HALF-1. When the counter is at HALF-1 it SHALL return to 0 and the output SHALL toggle. Period is 2*HALF clk cycles, duty cycle 50%.
REQ-015 slow_tick SHALL be 1 for exactly the clk cycle in which slow_clk changes 0->1, and 0 otherwise.
REQ-016 The two dividers SHALL be independent: neither resets nor stalls the other.
REQ-017 A HALF value of 1 SHALL toggle the output every clk cycle. HALF < 1 is illegal.

Reset
REQ-018 While reset_n=0, digits SHALL be 0, slow_clk, display_clk and slow_tick SHALL be 0, and divider counters SHALL be 0; this takes effect immediately, without a clk edge.
REQ-019 After reset_n rises, the first slow_clk toggle SHALL occur on the SLOW_HALF-th clk rising edge. The same rule applies to display_clk with DISP_HALF.
REQ-020 Reset asserted mid-period SHALL discard the partial period; there is no carry-over.

Configuration
REQ-021 The feature is the macro BCD_SATURATE_EN. When defined, count > 9999 SHALL yield digits 9,9,9,9. When undefined, the digits SHALL represent count mod 10000 (e.g. 12345 -> 2,3,4,5).

Structure
REQ-022 Package bcd_timebase_pkg SHALL hold the default SLOW_HALF and DISP_HALF values, the MAX_COUNT=9999 constant, and the digit width (8).
REQ-023 A sub-module clk_divider (parameter HALF; ports clk, reset_n, clk_out, rise) SHALL be instantiated twice, once per divided output.
REQ-024 The binary-to-decimal conversion SHALL be implemented with shift-add-3 (double dabble) combinational logic feeding the output registers. No divider operators are allowed.

Verification
REQ-025 Bench: count=0, then 1234, then 9999, then 10 -> one cycle later digits read 0/0/0/0, then 4,3,2,1, then 9,9,9,9, then 0,1,0,0 (digit0 listed first).
REQ-026 Bench: count=12345 -> 9,9,9,9 with BCD_SATURATE_EN defined, and 5,4,3,2 without it.
REQ-027 Bench: SLOW_HALF=5, DISP_HALF=2, release reset -> slow_clk toggles at edges 5, 10, 15, and display_clk toggles at edges 2, 4, 6. slow_tick is high only in the cycle of edges 5, 15, 25.
REQ-028 Bench: assert reset_n=0 between clk edges at mid-period -> all outputs read 0 immediately. After release, the first toggle occurs SLOW_HALF edges later.
REQ-029 Bench: exhaustive sweep of count 0..9999 -> every result matches a reference decimal model, and no digit ever exceeds 9.
REQ-030 Bench: count changes every clk cycle -> the digits track the change with exactly one cycle of lag and show no glitch values.
